// File: rtl/vec_alu_seq.sv
// Vector sequencer: streams one element pair per cycle through a shared external ALU
// and collects the results. Optional per-element masking is enabled by VEC_ALU_SEQ_MASK_EN.
module vec_alu_seq #(
    parameter int NUM_ELEM = 8,
    parameter int XLEN     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_sel,
    input  logic [4:0]               cmd_vl,
    input  logic [NUM_ELEM*XLEN-1:0] cmd_vs1,
    input  logic [NUM_ELEM*XLEN-1:0] cmd_vs2,
`ifdef VEC_ALU_SEQ_MASK_EN
    input  logic [NUM_ELEM-1:0]      cmd_mask,
    input  logic [NUM_ELEM*XLEN-1:0] cmd_vd_old,
`endif
    output logic [XLEN-1:0]          alu_opd1,
    output logic [XLEN-1:0]          alu_opd2,
    output logic [3:0]               alu_sel,
    input  logic [XLEN-1:0]          alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [NUM_ELEM*XLEN-1:0] res_data,
    output logic                     res_allzero
);

    localparam int VW = NUM_ELEM * XLEN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sel_q, sel_d;
    logic [VW-1:0]   vs1_q, vs1_d;
    logic [VW-1:0]   vs2_q, vs2_d;
    logic [VW-1:0]   res_q, res_d;
    logic [4:0]      vl_q, vl_d;
    logic [4:0]      idx_q, idx_d;
    logic            allzero_q, allzero_d;
    logic [4:0]      vl_eff;
    logic [XLEN-1:0] elem1, elem2, wr_val;
    logic            wr_counts;
`ifdef VEC_ALU_SEQ_MASK_EN
    logic [NUM_ELEM-1:0] mask_q, mask_d;
    logic [VW-1:0]       vd_old_q, vd_old_d;
    logic [XLEN-1:0]     vd_elem;
    logic                elem_mask;
`endif

    assign vl_eff = (cmd_vl > 5'(NUM_ELEM)) ? 5'(NUM_ELEM) : cmd_vl;

    always_comb begin
        elem1 = '0;
        elem2 = '0;
`ifdef VEC_ALU_SEQ_MASK_EN
        vd_elem   = '0;
        elem_mask = 1'b0;
`endif
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (idx_q == 5'(i)) begin
                elem1 = vs1_q[i*XLEN +: XLEN];
                elem2 = vs2_q[i*XLEN +: XLEN];
`ifdef VEC_ALU_SEQ_MASK_EN
                vd_elem   = vd_old_q[i*XLEN +: XLEN];
                elem_mask = mask_q[i];
`endif
            end
        end
    end

    // Masked-off elements keep their old destination value and do not vote on allzero.
    always_comb begin
`ifdef VEC_ALU_SEQ_MASK_EN
        wr_val    = elem_mask ? alu_result : vd_elem;
        wr_counts = elem_mask;
`else
        wr_val    = alu_result;
        wr_counts = 1'b1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        res_d     = res_q;
        vl_d      = vl_q;
        idx_d     = idx_q;
        allzero_d = allzero_q;
`ifdef VEC_ALU_SEQ_MASK_EN
        mask_d    = mask_q;
        vd_old_d  = vd_old_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sel_d     = cmd_sel;
                    vs1_d     = cmd_vs1;
                    vs2_d     = cmd_vs2;
                    vl_d      = vl_eff;
                    res_d     = '0;
                    idx_d     = '0;
                    allzero_d = 1'b1;
`ifdef VEC_ALU_SEQ_MASK_EN
                    mask_d    = cmd_mask;
                    vd_old_d  = cmd_vd_old;
`endif
                    state_d   = (vl_eff == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    if (idx_q == 5'(i)) res_d[i*XLEN +: XLEN] = wr_val;
                end
                if (wr_counts && (alu_result != '0)) allzero_d = 1'b0;
                idx_d = idx_q + 5'd1;
                if (idx_q == vl_q - 5'd1) state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            res_q     <= '0;
            vl_q      <= '0;
            idx_q     <= '0;
            allzero_q <= 1'b0;
`ifdef VEC_ALU_SEQ_MASK_EN
            mask_q    <= '0;
            vd_old_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            res_q     <= res_d;
            vl_q      <= vl_d;
            idx_q     <= idx_d;
            allzero_q <= allzero_d;
`ifdef VEC_ALU_SEQ_MASK_EN
            mask_q    <= mask_d;
            vd_old_q  <= vd_old_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign res_data    = res_q;
    assign res_allzero = allzero_q;
    assign alu_opd1    = (state_q == RUN) ? elem1 : '0;
    assign alu_opd2    = (state_q == RUN) ? elem2 : '0;
    assign alu_sel     = (state_q == RUN) ? sel_q : 4'd0;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed self-checking bench for vec_alu_seq with a small behavioural ALU attached.
module tb_vec_alu_seq;

    localparam int NE = 8;
    localparam int XL = 32;
    localparam int VW = NE * XL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_sel;
    logic [4:0]    cmd_vl;
    logic [VW-1:0] cmd_vs1, cmd_vs2;
`ifdef VEC_ALU_SEQ_MASK_EN
    logic [NE-1:0] cmd_mask;
    logic [VW-1:0] cmd_vd_old;
`endif
    logic [XL-1:0] alu_opd1, alu_opd2, alu_result;
    logic [3:0]    alu_sel;
    logic          res_valid, res_ready, res_allzero;
    logic [VW-1:0] res_data;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [VW-1:0] v1, v2, exp_v;
    int            cnt;

    vec_alu_seq #(.NUM_ELEM(NE), .XLEN(XL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_vl(cmd_vl),
        .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
`ifdef VEC_ALU_SEQ_MASK_EN
        .cmd_mask(cmd_mask), .cmd_vd_old(cmd_vd_old),
`endif
        .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_allzero(res_allzero)
    );

    always #5 clk = ~clk;

    // Reference ALU; undefined selects return a recognisable marker.
    always_comb begin
        case (alu_sel)
            4'b0000: alu_result = alu_opd1 & alu_opd2;
            4'b0001: alu_result = alu_opd1 | alu_opd2;
            4'b0010: alu_result = alu_opd1 + alu_opd2;
            4'b0110: alu_result = alu_opd1 - alu_opd2;
            4'b0111: alu_result = ($signed(alu_opd1) < $signed(alu_opd2)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_cmd(input logic [3:0] sel, input logic [4:0] vl,
                             input logic [VW-1:0] a, input logic [VW-1:0] b);
        cmd_sel   = sel;
        cmd_vl    = vl;
        cmd_vs1   = a;
        cmd_vs2   = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_sel = '0; cmd_vl = '0; cmd_vs1 = '0; cmd_vs2 = '0;
`ifdef VEC_ALU_SEQ_MASK_EN
        cmd_mask = '1; cmd_vd_old = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 1", cmd_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b expected 0", res_valid); end
        n_cmp++; if (res_data !== '0) begin n_fail++; $display("[TB] FAIL rst_data: got %h expected 0", res_data); end
        n_cmp++; if (res_allzero !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_allzero: got %b expected 0", res_allzero); end
        n_cmp++; if ({alu_opd1, alu_opd2, alu_sel} !== '0) begin n_fail++; $display("[TB] FAIL rst_alu: got %h %h %h expected 0", alu_opd1, alu_opd2, alu_sel); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        for (int i = 0; i < NE; i++) begin
            v1[i*XL +: XL]    = 32'(i);
            v2[i*XL +: XL]    = 32'd10;
            exp_v[i*XL +: XL] = (i < 4) ? 32'(10 + i) : 32'd0;
        end
        drive_cmd(4'b0010, 5'd4, v1, v2);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL add_busy: got %b expected 0", cmd_ready); end
        n_cmp++; if (alu_opd1 !== 32'd0 || alu_opd2 !== 32'd10 || alu_sel !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL add_drive: got %0d %0d %b expected 0 10 0010", alu_opd1, alu_opd2, alu_sel);
        end
        wait_valid(cnt);
        n_cmp++; if (cnt !== 4) begin n_fail++; $display("[TB] FAIL add_latency: got %0d expected 4", cnt); end
        n_cmp++; if (res_data !== exp_v) begin n_fail++; $display("[TB] FAIL add_data: got %h expected %h", res_data, exp_v); end
        n_cmp++; if (res_allzero !== 1'b0) begin n_fail++; $display("[TB] FAIL add_allzero: got %b expected 0", res_allzero); end
        n_cmp++; if ({alu_opd1, alu_opd2, alu_sel} !== '0) begin n_fail++; $display("[TB] FAIL done_alu_idle: got %h %h %h expected 0", alu_opd1, alu_opd2, alu_sel); end
        consume();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL add_idle: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_sub_zero();
        for (int i = 0; i < NE; i++) begin
            v1[i*XL +: XL] = 32'h5;
            v2[i*XL +: XL] = 32'h5;
        end
        drive_cmd(4'b0110, 5'd8, v1, v2);
        wait_valid(cnt);
        n_cmp++; if (cnt !== 8) begin n_fail++; $display("[TB] FAIL sub_latency: got %0d expected 8", cnt); end
        n_cmp++; if (res_data !== '0) begin n_fail++; $display("[TB] FAIL sub_data: got %h expected 0", res_data); end
        n_cmp++; if (res_allzero !== 1'b1) begin n_fail++; $display("[TB] FAIL sub_allzero: got %b expected 1", res_allzero); end
        consume();
    endtask

    task automatic test_vl_bounds();
        for (int i = 0; i < NE; i++) begin
            v1[i*XL +: XL]    = 32'(i + 1);
            v2[i*XL +: XL]    = 32'd0;
            exp_v[i*XL +: XL] = 32'(i + 1);
        end
        drive_cmd(4'b0010, 5'd0, v1, v2);
        wait_valid(cnt);
        n_cmp++; if (cnt !== 0) begin n_fail++; $display("[TB] FAIL vl0_latency: got %0d expected 0", cnt); end
        n_cmp++; if (res_data !== '0) begin n_fail++; $display("[TB] FAIL vl0_data: got %h expected 0", res_data); end
        n_cmp++; if (res_allzero !== 1'b1) begin n_fail++; $display("[TB] FAIL vl0_allzero: got %b expected 1", res_allzero); end
        consume();
        drive_cmd(4'b0010, 5'd20, v1, v2);
        wait_valid(cnt);
        n_cmp++; if (cnt !== 8) begin n_fail++; $display("[TB] FAIL vl20_latency: got %0d expected 8", cnt); end
        n_cmp++; if (res_data !== exp_v) begin n_fail++; $display("[TB] FAIL vl20_data: got %h expected %h", res_data, exp_v); end
        n_cmp++; if (res_allzero !== 1'b0) begin n_fail++; $display("[TB] FAIL vl20_allzero: got %b expected 0", res_allzero); end
        consume();
    endtask

    task automatic test_undefined_sel();
        v1 = '0; v2 = '0;
        exp_v = '0;
        exp_v[0 +: XL] = 32'hDEAD_BEEF;
        drive_cmd(4'b1111, 5'd1, v1, v2);
        n_cmp++; if (alu_sel !== 4'b1111) begin n_fail++; $display("[TB] FAIL undef_sel: got %b expected 1111", alu_sel); end
        wait_valid(cnt);
        n_cmp++; if (res_data !== exp_v) begin n_fail++; $display("[TB] FAIL undef_data: got %h expected %h", res_data, exp_v); end
        consume();
    endtask

    task automatic test_back_to_back();
        v1 = '0; v2 = '0; exp_v = '0;
        v1[0 +: XL] = 32'd1; v1[XL +: XL] = 32'd2;
        v2[0 +: XL] = 32'd3; v2[XL +: XL] = 32'd4;
        exp_v[0 +: XL] = 32'd4; exp_v[XL +: XL] = 32'd6;
        drive_cmd(4'b0010, 5'd2, v1, v2);
        wait_valid(cnt);
        n_cmp++; if (cnt !== 2) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 2", cnt); end
        cmd_sel = 4'b0010; cmd_vl = 5'd1;
        cmd_vs1 = '0; cmd_vs2 = '0;
        cmd_vs1[0 +: XL] = 32'd7; cmd_vs2[0 +: XL] = 32'd8;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (res_valid !== 1'b1 || res_data !== exp_v) begin
                n_fail++; $display("[TB] FAIL bp_hold: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp_v);
            end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready: got %b expected 0", cmd_ready); end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_handshake: got valid=%b ready=%b expected valid=0 ready=1", res_valid, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_accept: got %b expected 0", cmd_ready); end
        wait_valid(cnt);
        exp_v = '0; exp_v[0 +: XL] = 32'd15;
        n_cmp++; if (cnt !== 1 || res_data !== exp_v) begin
            n_fail++; $display("[TB] FAIL bp_second: got cnt=%0d data=%h expected cnt=1 data=%h", cnt, res_data, exp_v);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        for (int i = 0; i < NE; i++) begin
            v1[i*XL +: XL] = 32'(i + 1);
            v2[i*XL +: XL] = 32'd1;
        end
        drive_cmd(4'b0010, 5'd8, v1, v2);
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++; if (alu_opd1 !== 32'd3) begin n_fail++; $display("[TB] FAIL mid_elem2: got %0d expected 3", alu_opd1); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_state: got ready=%b valid=%b expected ready=1 valid=0", cmd_ready, res_valid);
        end
        n_cmp++; if (res_data !== '0 || alu_opd1 !== '0) begin
            n_fail++; $display("[TB] FAIL mid_clear: got data=%h opd1=%h expected 0", res_data, alu_opd1);
        end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (res_valid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("[TB] FAIL mid_no_valid: got %0d expected 0", pulses); end
    endtask

`ifdef VEC_ALU_SEQ_MASK_EN
    task automatic test_mask();
        for (int i = 0; i < NE; i++) begin
            v1[i*XL +: XL]         = 32'hFFFF_FFFF;
            v2[i*XL +: XL]         = 32'd0;
            cmd_vd_old[i*XL +: XL] = 32'hAA;
        end
        exp_v = '0;
        exp_v[0*XL +: XL] = 32'd1;
        exp_v[1*XL +: XL] = 32'hAA;
        exp_v[2*XL +: XL] = 32'd1;
        exp_v[3*XL +: XL] = 32'hAA;
        cmd_mask = 8'b0000_0101;
        drive_cmd(4'b0111, 5'd4, v1, v2);
        wait_valid(cnt);
        n_cmp++; if (cnt !== 4) begin n_fail++; $display("[TB] FAIL mask_latency: got %0d expected 4", cnt); end
        n_cmp++; if (res_data !== exp_v) begin n_fail++; $display("[TB] FAIL mask_data: got %h expected %h", res_data, exp_v); end
        n_cmp++; if (res_allzero !== 1'b0) begin n_fail++; $display("[TB] FAIL mask_allzero: got %b expected 0", res_allzero); end
        consume();
        cmd_mask = 8'b0000_0000;
        drive_cmd(4'b0111, 5'd2, v1, v2);
        wait_valid(cnt);
        n_cmp++; if (res_allzero !== 1'b1) begin n_fail++; $display("[TB] FAIL mask_excl: got %b expected 1", res_allzero); end
        consume();
        cmd_mask = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_vl_bounds();
        test_undefined_sel();
        test_back_to_back();
        test_reset_mid_run();
`ifdef VEC_ALU_SEQ_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
